calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Keystroke-to-ALU sequencer for the calculator. It turns single-cycle key pulses into operand A/B entry, with decimal shift-in and backspace. It then launches a multi-cycle ALU operation through a start/done handshake and presents the result for display. It sits between the key decoder and the ALU/display datapath and owns the operand registers.

## Interface
- WIDTH, 16: operand/result width (unsigned); must satisfy 2^WIDTH > 10^MAX_DIGITS.
- MAX_DIGITS, 4: maximum decimal digits per operand.
- TIMEOUT, 255: ALU watchdog limit in cycles (used only with CALC_SEQ_TIMEOUT_EN).
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dig_in  in  1  digit key pulse; digit  in  4  value, codes >9 ignored.
- op_in  in  1  operator key pulse; op_code  in  2  operator selection.
- eq_in, bksp_in, clr_in  in  1 each  equals / backspace / clear key pulses.
- alu_done  in  1  ALU completion; alu_err  in  1  ALU error, valid with alu_done; alu_result  in  WIDTH  valid with alu_done.
- operand_a, operand_b  out  WIDTH  ALU operands; alu_op  out  2  latched operator.
- alu_start  out  1  one-cycle launch pulse.
- display  out  WIDTH  value to show; busy  out  1  ALU in flight; error  out  1  error state.

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW, ERROR.
- Key priority within one cycle: clr > bksp > eq > op > digit. Only the highest-priority key is acted on.
- clr (any state): ENTER_A; A=B=0; counts=0; alu_op=0. A pending alu_done is ignored.
- ENTER_A:
  - digit: if count_a<MAX_DIGITS then A=A*10+digit and count_a++; otherwise ignored.
  - bksp: A=A/10 and count_a-- (floor at 0).
  - op: alu_op=op_code; B=0; count_b=0; go ENTER_B.
  - eq: ignored.
- ENTER_B:
  - digit and bksp act on B/count_b, with the same rules as in ENTER_A.
  - op with count_b==0: replace alu_op.
  - op with count_b>0: set chain flag; store op_code as pending op; launch as for eq.
  - eq with count_b>0: pulse alu_start; go EXEC. eq with count_b==0: ignored.
- EXEC: busy=1. Every key except clr is ignored. Operands and alu_op stay stable until done.
  - On alu_done with alu_err=1: go ERROR.
  - On alu_done without error: A=alu_result and count_a=MAX_DIGITS.
  - If chain is set: alu_op=pending op; B=0; count_b=0; chain cleared; go ENTER_B.
  - If chain is clear: go SHOW.
- SHOW:
  - digit: A=digit; count_a=1; go ENTER_A.
  - op: as op in ENTER_A, with A being the result.
  - bksp and eq: ignored.
- ERROR: error=1; display=0; only clr exits.
- display: B in ENTER_B when count_b>0; A in ENTER_B when count_b==0 and in ENTER_A/EXEC/SHOW; 0 in ERROR.
- All arithmetic is unsigned WIDTH-bit. Overflow cannot occur within the WIDTH constraint.

## Timing
- Reset values: state ENTER_A; operand_a=0; operand_b=0; alu_op=0; alu_start=0; display=0; busy=0; error=0; counts, chain and pending op all 0.
- Key pulses are sampled at posedge. Register and display updates are visible the cycle after the edge.
- Launch: if eq (or a chaining op) is accepted at edge N, alu_start is high for exactly the cycle between N and N+1, and busy rises at the same time.
- alu_done is sampled from edge N+1 onward, so a zero-latency ALU may assert it during the alu_start cycle. alu_done outside EXEC is ignored.
- alu_done accepted at edge M: busy=0, with new state and display after M.
- Reset mid-EXEC aborts the operation without a further alu_start.

## Configuration
- CALC_SEQ_TIMEOUT_EN defined:
  - An EXEC watchdog counts cycles from the alu_start cycle.
  - If alu_done is absent for TIMEOUT cycles, go ERROR, and later alu_done is ignored.
  - The watchdog is cleared on every EXEC entry.
- CALC_SEQ_TIMEOUT_EN undefined: no counter; EXEC waits indefinitely for alu_done or clr.

## Test plan
- Reset, then digits 1,2,3 -> display 1, 12, 123. Then bksp -> display 12, count_a=2.
- Five digits 9 with MAX_DIGITS=4 -> operand_a=9999; the fifth digit is ignored.
- Sequence 12, op 2'b01, 34, eq -> operand_a=12, operand_b=34, alu_op=1, exactly one alu_start pulse. ALU then returns done with result 46 after 3 cycles -> SHOW, display 46, busy low.
- Chaining: 5, op 0, 3, op 1 -> start pulse issued. Done with result 8 -> ENTER_B, alu_op=1, display 8. Then 2, eq -> operand_a=8, operand_b=2.
- Same cycle clr+dig_in in ENTER_A with A=77 -> A=0, digit discarded. alu_err=1 on done -> error=1, display 0, digits ignored until clr.
- With CALC_SEQ_TIMEOUT_EN and TIMEOUT=10, alu_done withheld -> ERROR after 10 cycles. A late alu_done has no effect.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keystroke sequencer: decimal operand entry, ALU start/done launch, result display.
// Define CALC_SEQ_TIMEOUT_EN to add an EXEC watchdog of TIMEOUT cycles.

module calc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dig_in,
    input  logic [3:0]       digit,
    input  logic             op_in,
    input  logic [1:0]       op_code,
    input  logic             eq_in,
    input  logic             bksp_in,
    input  logic             clr_in,
    input  logic             alu_done,
    input  logic             alu_err,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [WIDTH-1:0] TEN     = WIDTH'(10);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("calc_sequencer: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW,
        ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [CW-1:0]    cnt_a_q, cnt_a_nxt;
    logic [CW-1:0]    cnt_b_q, cnt_b_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [1:0]       pend_q, pend_nxt;
    logic             chain_q, chain_nxt;
    logic             start_q, start_nxt;
    logic             launch;
    logic             wd_expired;

    // Keys reduced to one-hot by priority clr > bksp > eq > op > digit
    logic k_clr, k_bksp, k_eq, k_op, k_dig;
    logic dig_ok;
    logic [WIDTH-1:0] digit_w;

    assign k_clr   = clr_in;
    assign k_bksp  = bksp_in & ~clr_in;
    assign k_eq    = eq_in & ~clr_in & ~bksp_in;
    assign k_op    = op_in & ~clr_in & ~bksp_in & ~eq_in;
    assign k_dig   = dig_in & ~clr_in & ~bksp_in & ~eq_in & ~op_in;
    assign dig_ok  = (digit <= 4'd9);
    assign digit_w = WIDTH'(digit);

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_q;

    // Zero outside EXEC, so every EXEC entry starts from a fresh count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state != EXEC) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_expired = (wd_q == TW'(TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            op_q    <= '0;
            pend_q  <= '0;
            chain_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            cnt_a_q <= cnt_a_nxt;
            cnt_b_q <= cnt_b_nxt;
            op_q    <= op_nxt;
            pend_q  <= pend_nxt;
            chain_q <= chain_nxt;
            start_q <= start_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        cnt_a_nxt = cnt_a_q;
        cnt_b_nxt = cnt_b_q;
        op_nxt    = op_q;
        pend_nxt  = pend_q;
        chain_nxt = chain_q;
        start_nxt = 1'b0;
        launch    = 1'b0;

        if (k_clr) begin
            state_nxt = ENTER_A;
            a_nxt     = '0;
            b_nxt     = '0;
            cnt_a_nxt = '0;
            cnt_b_nxt = '0;
            op_nxt    = '0;
            pend_nxt  = '0;
            chain_nxt = 1'b0;
        end else begin
            unique case (state)
                ENTER_A: begin
                    unique case (1'b1)
                        k_bksp: begin
                            a_nxt = a_q / TEN;
                            if (cnt_a_q != '0) cnt_a_nxt = cnt_a_q - 1'b1;
                        end
                        k_op: begin
                            op_nxt    = op_code;
                            b_nxt     = '0;
                            cnt_b_nxt = '0;
                            state_nxt = ENTER_B;
                        end
                        k_dig: begin
                            if (dig_ok && cnt_a_q < CNT_MAX) begin
                                a_nxt     = a_q * TEN + digit_w;
                                cnt_a_nxt = cnt_a_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                ENTER_B: begin
                    unique case (1'b1)
                        k_bksp: begin
                            b_nxt = b_q / TEN;
                            if (cnt_b_q != '0) cnt_b_nxt = cnt_b_q - 1'b1;
                        end
                        k_eq: begin
                            if (cnt_b_q != '0) launch = 1'b1;
                        end
                        k_op: begin
                            if (cnt_b_q == '0) begin
                                op_nxt = op_code;
                            end else begin
                                chain_nxt = 1'b1;
                                pend_nxt  = op_code;
                                launch    = 1'b1;
                            end
                        end
                        k_dig: begin
                            if (dig_ok && cnt_b_q < CNT_MAX) begin
                                b_nxt     = b_q * TEN + digit_w;
                                cnt_b_nxt = cnt_b_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            state_nxt = ERROR;
                            chain_nxt = 1'b0;
                        end else begin
                            a_nxt     = alu_result;
                            cnt_a_nxt = CNT_MAX;
                            if (chain_q) begin
                                op_nxt    = pend_q;
                                b_nxt     = '0;
                                cnt_b_nxt = '0;
                                chain_nxt = 1'b0;
                                state_nxt = ENTER_B;
                            end else begin
                                state_nxt = SHOW;
                            end
                        end
                    end else if (wd_expired) begin
                        state_nxt = ERROR;
                        chain_nxt = 1'b0;
                    end
                end
                SHOW: begin
                    unique case (1'b1)
                        k_op: begin
                            op_nxt    = op_code;
                            b_nxt     = '0;
                            cnt_b_nxt = '0;
                            state_nxt = ENTER_B;
                        end
                        k_dig: begin
                            if (dig_ok) begin
                                a_nxt     = digit_w;
                                cnt_a_nxt = CW'(1);
                                state_nxt = ENTER_A;
                            end
                        end
                        default: ;
                    endcase
                end
                ERROR: ;
                default: state_nxt = ENTER_A;
            endcase
        end

        if (launch) begin
            start_nxt = 1'b1;
            state_nxt = EXEC;
        end
    end

    assign operand_a = a_q;
    assign operand_b = b_q;
    assign alu_op    = op_q;
    assign alu_start = start_q;
    assign busy      = (state == EXEC);
    assign error     = (state == ERROR);
    assign display   = (state == ERROR) ? '0
                     : (state == ENTER_B && cnt_b_q != '0) ? b_q
                     : a_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random keys against a
// behavioural calculator model.

module tb_calc_sequencer;

    localparam int TMO = 10;
    localparam int M_A = 0, M_B = 1, M_EX = 2, M_SHOW = 3, M_ERR = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dig_in = 0, op_in = 0, eq_in = 0, bksp_in = 0, clr_in = 0;
    logic [3:0]  digit = 0;
    logic [1:0]  op_code = 0;
    logic        alu_done = 0, alu_err = 0;
    logic [15:0] alu_result = 0;
    logic [15:0] operand_a, operand_b, display;
    logic [1:0]  alu_op;
    logic        alu_start, busy, error;

    int n_cmp = 0;
    int n_fail = 0;
    int start_cnt = 0;

    int m_mode, m_a, m_b, m_ca, m_cb, m_op, m_chain, m_pend, m_wd;
    bit m_start;

    calc_sequencer #(.WIDTH(16), .MAX_DIGITS(4), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .dig_in(dig_in), .digit(digit),
        .op_in(op_in), .op_code(op_code),
        .eq_in(eq_in), .bksp_in(bksp_in), .clr_in(clr_in),
        .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
        .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
        .alu_start(alu_start), .display(display),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (alu_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
        m_op = 0; m_chain = 0; m_pend = 0; m_wd = 0; m_start = 0;
    endtask

    // Calculator behaviour for one clock edge, decided key by key
    task automatic model_step(input bit c, bk, e, o, d, input int dv, oc,
                              input bit dn, er, input int res);
        m_start = 0;
        if (c) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_A, M_SHOW: begin
                if (bk) begin
                    if (m_mode == M_A) begin
                        m_a = m_a / 10;
                        if (m_ca > 0) m_ca--;
                    end
                end else if (e) begin
                end else if (o) begin
                    m_op = oc; m_b = 0; m_cb = 0; m_mode = M_B;
                end else if (d && dv <= 9) begin
                    if (m_mode == M_SHOW) begin
                        m_a = dv; m_ca = 1; m_mode = M_A;
                    end else if (m_ca < 4) begin
                        m_a = (m_a * 10 + dv) % 65536; m_ca++;
                    end
                end
            end
            M_B: begin
                if (bk) begin
                    m_b = m_b / 10;
                    if (m_cb > 0) m_cb--;
                end else if (e) begin
                    if (m_cb > 0) begin m_start = 1; m_mode = M_EX; m_wd = 0; end
                end else if (o) begin
                    if (m_cb == 0) m_op = oc;
                    else begin
                        m_chain = 1; m_pend = oc;
                        m_start = 1; m_mode = M_EX; m_wd = 0;
                    end
                end else if (d && dv <= 9 && m_cb < 4) begin
                    m_b = (m_b * 10 + dv) % 65536; m_cb++;
                end
            end
            M_EX: begin
                if (dn) begin
                    if (er) begin
                        m_mode = M_ERR; m_chain = 0;
                    end else begin
                        m_a = res; m_ca = 4;
                        if (m_chain != 0) begin
                            m_op = m_pend; m_b = 0; m_cb = 0; m_chain = 0; m_mode = M_B;
                        end else m_mode = M_SHOW;
                    end
                end else begin
                    m_wd++;
`ifdef CALC_SEQ_TIMEOUT_EN
                    if (m_wd >= TMO) begin m_mode = M_ERR; m_chain = 0; end
`endif
                end
            end
            default: ;
        endcase
    endtask

    function automatic int exp_disp();
        if (m_mode == M_ERR) return 0;
        if (m_mode == M_B && m_cb > 0) return m_b;
        return m_a;
    endfunction

    task automatic tick(input bit c, bk, e, o, d, input int dv, oc,
                        input bit dn, er, input int res);
        @(negedge clock);
        clr_in = c; bksp_in = bk; eq_in = e; op_in = o; dig_in = d;
        digit = 4'(dv); op_code = 2'(oc);
        alu_done = dn; alu_err = er; alu_result = 16'(res);
        @(posedge clock);
        model_step(c, bk, e, o, d, dv, oc, dn, er, res);
        #1;
        clr_in = 0; bksp_in = 0; eq_in = 0; op_in = 0; dig_in = 0;
        digit = 0; op_code = 0; alu_done = 0; alu_err = 0; alu_result = 0;
    endtask

    task automatic key_dig(input int v);  tick(0,0,0,0,1,v,0,0,0,0); endtask
    task automatic key_op(input int c);   tick(0,0,0,1,0,0,c,0,0,0); endtask
    task automatic key_eq();              tick(0,0,1,0,0,0,0,0,0,0); endtask
    task automatic key_bksp();            tick(0,1,0,0,0,0,0,0,0,0); endtask
    task automatic key_clr();             tick(1,0,0,0,0,0,0,0,0,0); endtask
    task automatic idle();                tick(0,0,0,0,0,0,0,0,0,0); endtask
    task automatic done(input int r, input bit er); tick(0,0,0,0,0,0,0,1,er,r); endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clock);
        n_cmp++; if (operand_a !== 16'd0) begin n_fail++; $display("FAIL rst_a: got %0d want 0", operand_a); end
        n_cmp++; if (operand_b !== 16'd0) begin n_fail++; $display("FAIL rst_b: got %0d want 0", operand_b); end
        n_cmp++; if (alu_op !== 2'd0) begin n_fail++; $display("FAIL rst_op: got %0d want 0", alu_op); end
        n_cmp++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", alu_start); end
        n_cmp++; if (display !== 16'd0) begin n_fail++; $display("FAIL rst_disp: got %0d want 0", display); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", error); end
        reset = 1'b0;
    endtask

    task automatic test_entry();
        int kind[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int val[8]  = '{1, 2, 3, 0, 4, 5, 6, 0};
        int want[8] = '{1, 12, 123, 12, 124, 1245, 1245, 124};
        for (int i = 0; i < 8; i++) begin
            if (kind[i] == 0) key_dig(val[i]);
            else key_bksp();
            n_cmp++; if (display !== 16'(want[i])) begin n_fail++; $display("FAIL entry_%0d: got %0d want %0d", i, display, want[i]); end
        end
    endtask

    task automatic test_max_digits();
        key_clr();
        for (int i = 0; i < 5; i++) key_dig(9);
        n_cmp++; if (operand_a !== 16'd9999) begin n_fail++; $display("FAIL max_digits: got %0d want 9999", operand_a); end
        key_dig(12);
        n_cmp++; if (display !== 16'd9999) begin n_fail++; $display("FAIL bad_digit: got %0d want 9999", display); end
    endtask

    task automatic test_exec();
        int s0;
        key_clr();
        key_dig(1); key_dig(2); key_op(1);
        n_cmp++; if (display !== 16'd12) begin n_fail++; $display("FAIL exec_b_empty: got %0d want 12", display); end
        key_dig(3); key_dig(4);
        n_cmp++; if (display !== 16'd34) begin n_fail++; $display("FAIL exec_b_disp: got %0d want 34", display); end
        s0 = start_cnt;
        key_eq();
        n_cmp++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL exec_start: got %b want 1", alu_start); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL exec_busy: got %b want 1", busy); end
        n_cmp++; if (operand_a !== 16'd12 || operand_b !== 16'd34) begin n_fail++; $display("FAIL exec_ops: got %0d,%0d want 12,34", operand_a, operand_b); end
        n_cmp++; if (alu_op !== 2'd1) begin n_fail++; $display("FAIL exec_op: got %0d want 1", alu_op); end
        key_dig(7);
        n_cmp++; if (alu_start !== 1'b0 || operand_b !== 16'd34) begin n_fail++; $display("FAIL exec_hold: got start=%b b=%0d want 0,34", alu_start, operand_b); end
        done(46, 0);
        n_cmp++; if (display !== 16'd46 || busy !== 1'b0) begin n_fail++; $display("FAIL exec_done: got %0d busy=%b want 46 busy=0", display, busy); end
        n_cmp++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL exec_pulses: got %0d want 1", start_cnt - s0); end
        key_eq(); key_bksp();
        n_cmp++; if (display !== 16'd46) begin n_fail++; $display("FAIL show_ignore: got %0d want 46", display); end
        key_dig(5);
        n_cmp++; if (display !== 16'd5) begin n_fail++; $display("FAIL show_digit: got %0d want 5", display); end
    endtask

    task automatic test_chain();
        key_clr();
        key_dig(5); key_op(0); key_dig(3); key_op(1);
        n_cmp++; if (alu_start !== 1'b1 || alu_op !== 2'd0) begin n_fail++; $display("FAIL chain_start: got start=%b op=%0d want 1,0", alu_start, alu_op); end
        idle();
        done(8, 0);
        n_cmp++; if (alu_op !== 2'd1 || display !== 16'd8) begin n_fail++; $display("FAIL chain_done: got op=%0d disp=%0d want 1,8", alu_op, display); end
        n_cmp++; if (busy !== 1'b0 || operand_b !== 16'd0) begin n_fail++; $display("FAIL chain_b: got busy=%b b=%0d want 0,0", busy, operand_b); end
        key_dig(2); key_eq();
        n_cmp++; if (operand_a !== 16'd8 || operand_b !== 16'd2 || alu_start !== 1'b1) begin n_fail++; $display("FAIL chain_ops: got %0d,%0d,%b want 8,2,1", operand_a, operand_b, alu_start); end
        done(10, 0);
        n_cmp++; if (display !== 16'd10) begin n_fail++; $display("FAIL chain_res: got %0d want 10", display); end
    endtask

    task automatic test_priority();
        key_clr();
        key_dig(7); key_dig(7);
        tick(1,0,0,0,1,5,0,0,0,0);
        n_cmp++; if (operand_a !== 16'd0 || display !== 16'd0) begin n_fail++; $display("FAIL clr_dig: got %0d want 0", operand_a); end
        key_dig(3);
        tick(0,1,0,0,1,4,0,0,0,0);
        n_cmp++; if (display !== 16'd0) begin n_fail++; $display("FAIL bksp_dig: got %0d want 0", display); end
        key_dig(6);
        tick(0,0,0,1,1,9,2,0,0,0);
        n_cmp++; if (alu_op !== 2'd2 || display !== 16'd6) begin n_fail++; $display("FAIL op_dig: got op=%0d disp=%0d want 2,6", alu_op, display); end
    endtask

    task automatic test_error();
        key_clr();
        key_dig(1); key_op(3); key_dig(2); key_eq();
        done(0, 1);
        n_cmp++; if (error !== 1'b1 || display !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_enter: got err=%b disp=%0d busy=%b want 1,0,0", error, display, busy); end
        key_dig(4); key_eq();
        n_cmp++; if (error !== 1'b1 || display !== 16'd0) begin n_fail++; $display("FAIL err_stay: got err=%b disp=%0d want 1,0", error, display); end
        key_clr();
        n_cmp++; if (error !== 1'b0 || display !== 16'd0) begin n_fail++; $display("FAIL err_clr: got err=%b disp=%0d want 0,0", error, display); end
    endtask

    task automatic test_zero_latency();
        key_clr();
        key_dig(4); key_op(0); key_dig(5); key_eq();
        done(9, 0);
        n_cmp++; if (display !== 16'd9 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_lat: got %0d busy=%b want 9,0", display, busy); end
        done(123, 0);
        n_cmp++; if (display !== 16'd9) begin n_fail++; $display("FAIL stray_done: got %0d want 9", display); end
    endtask

    task automatic test_reset_mid_exec();
        int s0;
        key_clr();
        key_dig(1); key_op(0); key_dig(1); key_eq();
        @(negedge clock);
        s0 = start_cnt;
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || alu_start !== 1'b0 || operand_a !== 16'd0) begin n_fail++; $display("FAIL rst_exec: got busy=%b start=%b a=%0d want 0,0,0", busy, alu_start, operand_a); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        idle(); idle(); idle();
        n_cmp++; if (start_cnt !== s0) begin n_fail++; $display("FAIL rst_nostart: got %0d want %0d", start_cnt, s0); end
    endtask

`ifdef CALC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        key_clr();
        key_dig(1); key_op(0); key_dig(2); key_eq();
        for (int i = 1; i < TMO; i++) idle();
        n_cmp++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got busy=%b err=%b want 1,0", busy, error); end
        idle();
        n_cmp++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: got err=%b busy=%b want 1,0", error, busy); end
        done(3, 0);
        n_cmp++; if (error !== 1'b1 || display !== 16'd0) begin n_fail++; $display("FAIL tmo_late: got err=%b disp=%0d want 1,0", error, display); end
        key_clr();
    endtask
`endif

    task automatic test_random();
        bit c, bk, e, o, d, dn, er;
        int dv, oc, res;
        key_clr();
        for (int i = 0; i < 800; i++) begin
            c  = ($urandom_range(0, 99) < 3);
            bk = ($urandom_range(0, 99) < 10);
            e  = ($urandom_range(0, 99) < 15);
            o  = ($urandom_range(0, 99) < 15);
            d  = ($urandom_range(0, 99) < 55);
            dv = $urandom_range(0, 11);
            oc = $urandom_range(0, 3);
            if (m_mode == M_EX) dn = ($urandom_range(0, 99) < 40);
            else dn = ($urandom_range(0, 99) < 5);
            er  = ($urandom_range(0, 99) < 10);
            res = $urandom_range(0, 9999);
            tick(c, bk, e, o, d, dv, oc, dn, er, res);
            n_cmp++; if (display !== 16'(exp_disp())) begin n_fail++; $display("FAIL rnd_disp@%0d: got %0d want %0d", i, display, exp_disp()); end
            n_cmp++; if (operand_a !== 16'(m_a) || operand_b !== 16'(m_b)) begin n_fail++; $display("FAIL rnd_ops@%0d: got %0d,%0d want %0d,%0d", i, operand_a, operand_b, m_a, m_b); end
            n_cmp++; if (alu_op !== 2'(m_op)) begin n_fail++; $display("FAIL rnd_op@%0d: got %0d want %0d", i, alu_op, m_op); end
            n_cmp++; if (alu_start !== m_start) begin n_fail++; $display("FAIL rnd_start@%0d: got %b want %b", i, alu_start, m_start); end
            n_cmp++; if (busy !== (m_mode == M_EX)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", i, busy, m_mode == M_EX); end
            n_cmp++; if (error !== (m_mode == M_ERR)) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", i, error, m_mode == M_ERR); end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_max_digits();
        test_exec();
        test_chain();
        test_priority();
        test_error();
        test_zero_latency();
        test_reset_mid_exec();
`ifdef CALC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
